// File: rtl/reg_scoreboard.sv
// Per-register issue-latency scoreboard: counts down the cycles before each pending
// destination becomes forwardable and stalls ID while a source operand is still waiting.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int LAT_W    = 3,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   id_rs,
    input  logic [ADDR_W-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                issue_valid,
    input  logic                issue_regwrite,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                flush,
    output logic                stall,
    output logic                stall_rs,
    output logic                stall_rt,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    logic [LAT_W-1:0]    cnt_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_s;
    logic                stallRs_s;
    logic                stallRt_s;
    logic                stall_s;
    logic                accepted_s;
    logic [PERF_W-1:0]   stallCycles_r;

    // Busy flags and stall decode, driven only from registered counts.
    always_comb begin
        busy_s = {NUM_REGS{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt_r[r] != {LAT_W{1'b0}}) begin
                busy_s[r] = 1'b1;
            end else begin
                busy_s[r] = 1'b0;
            end
        end
        stallRs_s  = id_use_rs & (id_rs != {ADDR_W{1'b0}}) & busy_s[id_rs];
        stallRt_s  = id_use_rt & (id_rt != {ADDR_W{1'b0}}) & busy_s[id_rt];
        stall_s    = stallRs_s | stallRt_s;
        accepted_s = issue_valid & ~stall_s & ~flush;
    end

    // Per-register wait counters; r0 never holds a pending write.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst || flush || (r == 0)) begin
                cnt_r[r] <= {LAT_W{1'b0}};
            end else if (accepted_s && issue_regwrite && (issue_rd == ADDR_W'(r))) begin
                cnt_r[r] <= issue_lat;
            end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
                cnt_r[r] <= cnt_r[r] - {{(LAT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r[r] <= {LAT_W{1'b0}};
            end
        end
    end

    // Saturating stall-cycle counter; a flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles_r <= {PERF_W{1'b0}};
        end else if (stall_s && (stallCycles_r != PERF_MAX)) begin
            stallCycles_r <= stallCycles_r + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            stallCycles_r <= stallCycles_r;
        end
    end

    assign stall        = stall_s;
    assign stall_rs     = stallRs_s;
    assign stall_rt     = stallRt_s;
    assign busy_mask    = busy_s;
    assign stall_cycles = stallCycles_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, operand sweep, a table of issue/consume
// vectors, and a hand-written saturation sequence on a narrow stall counter.
module tb_reg_scoreboard;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    id_rs = 5'd0;
    logic [4:0]    id_rt = 5'd0;
    logic          id_use_rs = 1'b0;
    logic          id_use_rt = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_regwrite = 1'b0;
    logic [4:0]    issue_rd = 5'd0;
    logic [2:0]    issue_lat = 3'd0;
    logic          flush = 1'b0;
    logic          stall;
    logic          stall_rs;
    logic          stall_rt;
    logic [31:0]   busy_mask;
    logic [PW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .LAT_W(3), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .issue_valid(issue_valid), .issue_regwrite(issue_regwrite),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
        .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt),
        .busy_mask(busy_mask), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, flush, iv, rw;
        logic [4:0]    rd;
        logic [2:0]    lat;
        logic [4:0]    rs;
        logic          urs;
        logic [4:0]    rt;
        logic          urt;
        logic          eStall, eSrs, eSrt;
        logic [31:0]   eBusy;
        logic [PW-1:0] eSc;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic rw,
                                input logic [4:0] rd, input logic [2:0] lat,
                                input logic [4:0] rs, input logic urs,
                                input logic [4:0] rt, input logic urt,
                                input logic es, input logic esrs, input logic esrt,
                                input logic [31:0] eb, input logic [PW-1:0] esc);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.rw = rw; v.rd = rd; v.lat = lat;
        v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
        v.eStall = es; v.eSrs = esrs; v.eSrt = esrt; v.eBusy = eb; v.eSc = esc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; flush = v.flush; issue_valid = v.iv; issue_regwrite = v.rw;
        issue_rd = v.rd; issue_lat = v.lat;
        id_rs = v.rs; id_use_rs = v.urs; id_rt = v.rt; id_use_rt = v.urt;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_regwrite = 1'b0;
        issue_rd = 5'd0; issue_lat = 3'd0;
        id_rs = 5'd0; id_use_rs = 1'b0; id_rt = 5'd0; id_use_rt = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] expSc;

        // rst, flush, iv, rw, rd, lat, rs, urs, rt, urt | stall, srs, srt, busy, sc
        vecs[0]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  3'd1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  3'd2, 5'd5,  1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20,  4'd0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 5'd5,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd1);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  3'd3, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd1);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 5'd0,  1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 4'd1);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 5'd0,  1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 4'd2);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 5'd0,  1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 4'd3);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 5'd0,  1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   4'd4);
        vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  3'd3, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd4);
        vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  3'd0, 5'd7,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80,  4'd4);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  3'd2, 5'd7,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd4);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd3,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd4);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  3'd7, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd4);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd2,  3'd2, 5'd0,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd4);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd2,  1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4,   4'd4);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd0,  1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4,   4'd4);
        vecs[16] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  3'd3, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd5);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  3'd0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,  4'd5);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd4,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd5);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  3'd2, 5'd8,  1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd5);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  3'd1, 5'd8,  1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 4'd5);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd8,  1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 4'd6);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd7);
        vecs[23] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 3'd3, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd7);
        vecs[24] = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 4'd7);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0);

        // Reset state
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset busy", busy_mask, 32'd0);
        check("reset stall_cycles", {28'd0, stall_cycles}, 32'd0);

        // Operand sweep with nothing pending
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            id_rs = 5'(i); id_rt = 5'(31 - i);
            id_use_rs = 1'b1; id_use_rt = 1'b1;
            #2;
            check($sformatf("sweep%0d stall", i), {31'd0, stall}, 32'd0);
        end

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            check($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].eStall});
            check($sformatf("row%0d stall_rs", i), {31'd0, stall_rs}, {31'd0, vecs[i].eSrs});
            check($sformatf("row%0d stall_rt", i), {31'd0, stall_rt}, {31'd0, vecs[i].eSrt});
            check($sformatf("row%0d busy", i), busy_mask, vecs[i].eBusy);
            check($sformatf("row%0d stall_cycles", i), {28'd0, stall_cycles}, {28'd0, vecs[i].eSc});
        end

        // Drive the stall counter into saturation with three lat=7 producers
        expSc = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 5'd11; issue_lat = 3'd7;
            #2;
            check($sformatf("sat%0d issue stall", k), {31'd0, stall}, 32'd0);
            for (int j = 0; j < 7; j++) begin
                @(negedge clk);
                idle();
                id_rs = 5'd11; id_use_rs = 1'b1;
                #2;
                check($sformatf("sat%0d.%0d stall", k, j), {31'd0, stall}, 32'd1);
                check($sformatf("sat%0d.%0d stall_cycles", k, j), {28'd0, stall_cycles}, {28'd0, expSc});
                if (expSc != {PW{1'b1}}) begin
                    expSc = expSc + 4'd1;
                end
            end
        end
        @(negedge clk);
        idle();
        id_rs = 5'd11; id_use_rs = 1'b1;
        #2;
        check("sat end stall", {31'd0, stall}, 32'd0);
        check("sat end stall_cycles", {28'd0, stall_cycles}, 32'd15);

        // Flush must not clear the saturated counter
        @(negedge clk);
        idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        check("post-flush stall_cycles", {28'd0, stall_cycles}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
